// File: rtl/cmp_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_cmd_sequencer_if
//  Description : Host request/response channel plus engine command/response
//                signals for the compression engine command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmp_cmd_sequencer_if;
   // Host request channel
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic [79:0] req_data;
   logic [7:0]  req_code;
   // Engine side
   logic [1:0]  command;
   logic [79:0] data_in;
   logic [7:0]  compressed_in;
   logic [7:0]  compressed_out;
   logic [79:0] decompressed_out;
   logic [1:0]  response;
   // Host result channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_status;
   logic [7:0]  rsp_code;
   logic [79:0] rsp_data;
   logic [7:0]  timeout_cnt;

   // Environment view: host plus engine model
   modport master (
      output req_valid, req_cmd, req_data, req_code,
      output compressed_out, decompressed_out, response,
      output rsp_ready,
      input  req_ready, command, data_in, compressed_in,
      input  rsp_valid, rsp_status, rsp_code, rsp_data, timeout_cnt
   );

   // Sequencer view
   modport slave (
      input  req_valid, req_cmd, req_data, req_code,
      input  compressed_out, decompressed_out, response,
      input  rsp_ready,
      output req_ready, command, data_in, compressed_in,
      output rsp_valid, rsp_status, rsp_code, rsp_data, timeout_cnt
   );
endinterface
`default_nettype wire

// File: rtl/cmp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_cmd_sequencer
//  Description : Buffers host requests in a FIFO, issues them one at a time
//                to the compression engine as single-cycle command pulses,
//                waits for the engine response or a timeout and returns the
//                result on a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  wire                 clk,
   input  wire                 reset,
   cmp_cmd_sequencer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam int EW = 2 + 80 + 8;
   localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [EW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   // Sequencer state and registered outputs
   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_command;
   logic [79:0]   r_data_in;
   logic [7:0]    r_code_in;
   logic          r_rsp_valid;
   logic [1:0]    r_rsp_status;
   logic [7:0]    r_rsp_code;
   logic [79:0]   r_rsp_data;
   logic [7:0]    r_timeout_cnt;

   logic          w_empty;
   logic          w_full;
   logic          w_req_ready;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_head;
   logic [1:0]    w_head_cmd;
   logic [79:0]   w_head_data;
   logic [7:0]    w_head_code;

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Held low while reset is asserted so every output reads 0 in reset.
   assign w_req_ready = !w_full && !reset;
   assign w_push      = bus.req_valid && w_req_ready;
   assign w_pop       = (r_state == S_IDLE) && !w_empty;

   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_head_cmd  = w_head[EW-1 -: 2];
   assign w_head_data = w_head[87:8];
   assign w_head_code = w_head[7:0];

   // FIFO payload write; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {bus.req_cmd, bus.req_data, bus.req_code};
      end
   end

   // FIFO pointer update, wrapping modulo DEPTH through natural overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Command sequencing FSM with registered engine and host outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_command     <= 2'b00;
         r_data_in     <= '0;
         r_code_in     <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_status  <= 2'b00;
         r_rsp_code    <= '0;
         r_rsp_data    <= '0;
         r_timeout_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_command <= 2'b00;
               // No-op entries are popped and dropped without a response.
               if (w_pop && (w_head_cmd != 2'b00)) begin
                  r_command <= w_head_cmd;
                  r_data_in <= w_head_data;
                  r_code_in <= w_head_code;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_command <= 2'b00;
               r_timer   <= '0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // A real response beats a timeout landing in the same cycle.
               if (bus.response != 2'b00) begin
                  r_rsp_status <= bus.response;
                  r_rsp_code   <= bus.compressed_out;
                  r_rsp_data   <= bus.decompressed_out;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= S_RESP;
               end else if (r_timer == c_TMO_LAST) begin
                  r_rsp_status <= 2'b11;
                  r_rsp_code   <= '0;
                  r_rsp_data   <= '0;
                  r_rsp_valid  <= 1'b1;
                  if (r_timeout_cnt != 8'hFF) begin
                     r_timeout_cnt <= r_timeout_cnt + 8'd1;
                  end
                  r_state      <= S_RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready     = w_req_ready;
   assign bus.command       = r_command;
   assign bus.data_in       = r_data_in;
   assign bus.compressed_in = r_code_in;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_status    = r_rsp_status;
   assign bus.rsp_code      = r_rsp_code;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.timeout_cnt   = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_cmd_sequencer
//  Description : Directed self-checking bench for cmp_cmd_sequencer.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmp_cmd_sequencer;

   localparam logic [79:0] c_WORD = 80'h0123456789ABCDEF0011;
   localparam logic [79:0] c_HELD = 80'h0000000000000000BEEF;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   cmp_cmd_sequencer_if u_bus();

   cmp_cmd_sequencer #(.DEPTH(4), .TIMEOUT(64)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (u_bus.command !== 2'b00) begin n_err++; $display("FAIL reset_command: got %b want 00", u_bus.command); end
      n_cmp++; if (u_bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", u_bus.rsp_valid); end
      n_cmp++; if (u_bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready_in_reset: got %b want 0", u_bus.req_ready); end
      n_cmp++; if (u_bus.timeout_cnt !== 8'd0) begin n_err++; $display("FAIL reset_timeout_cnt: got %0d want 0", u_bus.timeout_cnt); end
      n_cmp++; if (u_bus.data_in !== 80'd0) begin n_err++; $display("FAIL reset_data_in: got %h want 0", u_bus.data_in); end
      reset = 1'b0;
      #1;
      n_cmp++; if (u_bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready_after: got %b want 1", u_bus.req_ready); end
      @(negedge clk);
   endtask

   task automatic test_compress();
      u_bus.req_valid = 1'b1; u_bus.req_cmd = 2'b01; u_bus.req_data = c_WORD; u_bus.req_code = 8'h00;
      @(negedge clk);
      u_bus.req_valid = 1'b0;
      n_cmp++; if (u_bus.command !== 2'b00) begin n_err++; $display("FAIL cmp_cmd_pre: got %b want 00", u_bus.command); end
      @(negedge clk);
      n_cmp++; if (u_bus.command !== 2'b01) begin n_err++; $display("FAIL cmp_cmd_pulse: got %b want 01", u_bus.command); end
      n_cmp++; if (u_bus.data_in !== c_WORD) begin n_err++; $display("FAIL cmp_data_in: got %h want %h", u_bus.data_in, c_WORD); end
      @(negedge clk);
      n_cmp++; if (u_bus.command !== 2'b00) begin n_err++; $display("FAIL cmp_cmd_one_cycle: got %b want 00", u_bus.command); end
      @(negedge clk);
      n_cmp++; if (u_bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL cmp_rsp_early: got %b want 0", u_bus.rsp_valid); end
      u_bus.response = 2'b01; u_bus.compressed_out = 8'h05;
      @(negedge clk);
      u_bus.response = 2'b00; u_bus.compressed_out = 8'h00;
      n_cmp++; if (u_bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL cmp_rsp_valid: got %b want 1", u_bus.rsp_valid); end
      n_cmp++; if (u_bus.rsp_status !== 2'b01) begin n_err++; $display("FAIL cmp_rsp_status: got %b want 01", u_bus.rsp_status); end
      n_cmp++; if (u_bus.rsp_code !== 8'h05) begin n_err++; $display("FAIL cmp_rsp_code: got %h want 05", u_bus.rsp_code); end
      u_bus.rsp_ready = 1'b1;
      @(negedge clk);
      u_bus.rsp_ready = 1'b0;
      n_cmp++; if (u_bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL cmp_rsp_drop: got %b want 0", u_bus.rsp_valid); end
   endtask

   task automatic test_decompress();
      u_bus.req_valid = 1'b1; u_bus.req_cmd = 2'b10; u_bus.req_data = c_HELD; u_bus.req_code = 8'h05;
      @(negedge clk);
      u_bus.req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (u_bus.command !== 2'b10) begin n_err++; $display("FAIL dec_cmd_pulse: got %b want 10", u_bus.command); end
      n_cmp++; if (u_bus.compressed_in !== 8'h05) begin n_err++; $display("FAIL dec_code_issue: got %h want 05", u_bus.compressed_in); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++; if (u_bus.compressed_in !== 8'h05) begin n_err++; $display("FAIL dec_code_stable[%0d]: got %h want 05", k, u_bus.compressed_in); end
         n_cmp++; if (u_bus.data_in !== c_HELD) begin n_err++; $display("FAIL dec_data_stable[%0d]: got %h want %h", k, u_bus.data_in, c_HELD); end
      end
      u_bus.response = 2'b10; u_bus.decompressed_out = c_WORD;
      @(negedge clk);
      u_bus.response = 2'b00; u_bus.decompressed_out = 80'd0;
      n_cmp++; if (u_bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL dec_rsp_valid: got %b want 1", u_bus.rsp_valid); end
      n_cmp++; if (u_bus.rsp_status !== 2'b10) begin n_err++; $display("FAIL dec_rsp_status: got %b want 10", u_bus.rsp_status); end
      n_cmp++; if (u_bus.rsp_data !== c_WORD) begin n_err++; $display("FAIL dec_rsp_data: got %h want %h", u_bus.rsp_data, c_WORD); end
      u_bus.rsp_ready = 1'b1;
      @(negedge clk);
      u_bus.rsp_ready = 1'b0;
   endtask

   task automatic test_noop_filter();
      logic [1:0] cmds [3];
      logic       saw;
      int         pulses;
      int         rsps;
      logic [1:0] last_cmd;
      cmds[0] = 2'b00; cmds[1] = 2'b01; cmds[2] = 2'b00;
      for (int i = 0; i < 3; i++) begin
         u_bus.req_valid = 1'b1; u_bus.req_cmd = cmds[i]; u_bus.req_data = 80'd0; u_bus.req_code = 8'd0;
         @(negedge clk);
      end
      u_bus.req_valid = 1'b0;
      u_bus.rsp_ready = 1'b1;
      saw = 1'b0; pulses = 0; rsps = 0; last_cmd = 2'b00;
      // Engine model answers in the cycle after each command pulse.
      for (int i = 0; i < 20; i++) begin
         u_bus.response = saw ? 2'b01 : 2'b00;
         saw = (u_bus.command != 2'b00);
         if (saw) begin pulses++; last_cmd = u_bus.command; end
         if (u_bus.rsp_valid) rsps++;
         @(negedge clk);
      end
      u_bus.response = 2'b00;
      u_bus.rsp_ready = 1'b0;
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL noop_pulses: got %0d want 1", pulses); end
      n_cmp++; if (last_cmd !== 2'b01) begin n_err++; $display("FAIL noop_pulse_cmd: got %b want 01", last_cmd); end
      n_cmp++; if (rsps !== 1) begin n_err++; $display("FAIL noop_rsp_count: got %0d want 1", rsps); end
   endtask

   task automatic test_timeout_boundary();
      u_bus.req_valid = 1'b1; u_bus.req_cmd = 2'b01; u_bus.req_data = 80'd0; u_bus.req_code = 8'd0;
      @(negedge clk);
      u_bus.req_valid = 1'b0;
      // Lands on the last WAIT cycle, where the timer holds 63.
      repeat (65) @(negedge clk);
      n_cmp++; if (u_bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_edge_early: got %b want 0", u_bus.rsp_valid); end
      u_bus.response = 2'b11; u_bus.compressed_out = 8'hA5;
      @(negedge clk);
      u_bus.response = 2'b00; u_bus.compressed_out = 8'h00;
      n_cmp++; if (u_bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL tmo_edge_valid: got %b want 1", u_bus.rsp_valid); end
      n_cmp++; if (u_bus.rsp_status !== 2'b11) begin n_err++; $display("FAIL tmo_edge_status: got %b want 11", u_bus.rsp_status); end
      n_cmp++; if (u_bus.rsp_code !== 8'hA5) begin n_err++; $display("FAIL tmo_edge_code: got %h want a5", u_bus.rsp_code); end
      n_cmp++; if (u_bus.timeout_cnt !== 8'd0) begin n_err++; $display("FAIL tmo_edge_cnt: got %0d want 0", u_bus.timeout_cnt); end
      u_bus.rsp_ready = 1'b1;
      @(negedge clk);
      u_bus.rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      for (int i = 0; i < 6; i++) begin
         u_bus.req_valid = 1'b1; u_bus.req_cmd = 2'b01; u_bus.req_data = 80'(i + 1); u_bus.req_code = 8'(i);
         n_cmp++; if (u_bus.req_ready !== (i < 5)) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want %b", i, u_bus.req_ready, (i < 5)); end
         @(negedge clk);
      end
      u_bus.req_valid = 1'b0;
      n = 0;
      while (!u_bus.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (n !== 61) begin n_err++; $display("FAIL bp_timeout_latency: got %0d want 61", n); end
      n_cmp++; if (u_bus.rsp_status !== 2'b11) begin n_err++; $display("FAIL bp_status: got %b want 11", u_bus.rsp_status); end
      n_cmp++; if (u_bus.rsp_code !== 8'h00) begin n_err++; $display("FAIL bp_code: got %h want 00", u_bus.rsp_code); end
      n_cmp++; if (u_bus.rsp_data !== 80'd0) begin n_err++; $display("FAIL bp_data: got %h want 0", u_bus.rsp_data); end
      n_cmp++; if (u_bus.timeout_cnt !== 8'd1) begin n_err++; $display("FAIL bp_timeout_cnt: got %0d want 1", u_bus.timeout_cnt); end
      n_cmp++; if (u_bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full: got %b want 0", u_bus.req_ready); end
      u_bus.rsp_ready = 1'b1;
      @(negedge clk);
      u_bus.rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (u_bus.command !== 2'b01) begin n_err++; $display("FAIL bp_next_issue: got %b want 01", u_bus.command); end
      n_cmp++; if (u_bus.data_in !== 80'd2) begin n_err++; $display("FAIL bp_next_data: got %h want 2", u_bus.data_in); end
      n_cmp++; if (u_bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_space_freed: got %b want 1", u_bus.req_ready); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      int pulses;
      int rsps;
      int n;
      reset = 1'b1;
      #1;
      n_cmp++; if (u_bus.command !== 2'b00) begin n_err++; $display("FAIL rst_wait_command: got %b want 00", u_bus.command); end
      n_cmp++; if (u_bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_wait_rsp_valid: got %b want 0", u_bus.rsp_valid); end
      n_cmp++; if (u_bus.timeout_cnt !== 8'd0) begin n_err++; $display("FAIL rst_wait_timeout_cnt: got %0d want 0", u_bus.timeout_cnt); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (u_bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_wait_ready: got %b want 1", u_bus.req_ready); end
      pulses = 0; rsps = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_bus.command != 2'b00) pulses++;
         if (u_bus.rsp_valid) rsps++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_wait_stale_pulses: got %0d want 0", pulses); end
      n_cmp++; if (rsps !== 0) begin n_err++; $display("FAIL rst_wait_stale_rsps: got %0d want 0", rsps); end
      u_bus.req_valid = 1'b1; u_bus.req_cmd = 2'b01; u_bus.req_data = c_WORD; u_bus.req_code = 8'd0;
      @(negedge clk);
      u_bus.req_valid = 1'b0;
      n = 0;
      while (u_bus.command == 2'b00 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (n !== 1) begin n_err++; $display("FAIL rst_new_issue_latency: got %0d want 1", n); end
      n_cmp++; if (u_bus.data_in !== c_WORD) begin n_err++; $display("FAIL rst_new_data: got %h want %h", u_bus.data_in, c_WORD); end
      @(negedge clk);
      u_bus.response = 2'b01; u_bus.compressed_out = 8'h3C;
      @(negedge clk);
      u_bus.response = 2'b00; u_bus.compressed_out = 8'h00;
      n_cmp++; if (u_bus.rsp_code !== 8'h3C) begin n_err++; $display("FAIL rst_new_code: got %h want 3c", u_bus.rsp_code); end
      u_bus.rsp_ready = 1'b1;
      @(negedge clk);
      u_bus.rsp_ready = 1'b0;
   endtask

   initial begin
      u_bus.req_valid = 1'b0; u_bus.req_cmd = 2'b00; u_bus.req_data = 80'd0; u_bus.req_code = 8'd0;
      u_bus.compressed_out = 8'd0; u_bus.decompressed_out = 80'd0; u_bus.response = 2'b00;
      u_bus.rsp_ready = 1'b0;
      test_reset();
      test_compress();
      test_decompress();
      test_noop_filter();
      test_timeout_boundary();
      test_backpressure();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
